// File: rtl/swap_engine_if.sv
// Request and RAM-port bundle for swap_engine.
// Handshake: start is a request that is accepted only while the engine is
// idle (busy=0); once accepted, busy stays high up to and including the
// single done cycle, and start/addr_i/addr_j are ignored until busy drops.
// val_i/val_j hold the pre-swap words from done until the next accepted start.
interface swap_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W-1:0] addr_j;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] val_i;
    logic [DATA_W-1:0] val_j;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Controller plus RAM side: issues requests and returns read data.
    modport master (
        output start, addr_i, addr_j, mem_rdata,
        input  busy, done, val_i, val_j, mem_addr, mem_wren, mem_wdata
    );

    // Engine side.
    modport slave (
        input  start, addr_i, addr_j, mem_rdata,
        output busy, done, val_i, val_j, mem_addr, mem_wren, mem_wdata
    );
endinterface

// File: rtl/swap_engine.sv
// Read-read-write-write swap of two words in a single-port synchronous RAM.
// Reads mem[ai] and mem[aj], writes each to the other location, returns the
// old values and pulses done. All RAM port signals are registered.
module swap_engine #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int SKIP_SAME = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    swap_engine_if.slave bus,
    output logic [2:0] dbg_state_o
);
    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_I = 3'd1,
        S_RD_J = 3'd2,
        S_WR_I = 3'd3,
        S_WR_J = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] ai_q;
    logic [ADDR_W-1:0] aj_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wren_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] val_i_q;
    logic [DATA_W-1:0] val_j_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_last;
    logic              same_addr;

    // Each read state holds its address for RD_LAT+1 cycles; the last edge
    // of that window is where read data is valid.
    assign rd_last   = (cnt_q == CNT_W'(RD_LAT));
    assign same_addr = (SKIP_SAME != 0) && (ai_q == aj_q);

    // Sequencer: state, wait counter, latched addresses and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ai_q        <= '0;
            aj_q        <= '0;
            mem_addr_q  <= '0;
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= '0;
            val_i_q     <= '0;
            val_j_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        ai_q       <= bus.addr_i;
                        aj_q       <= bus.addr_j;
                        mem_addr_q <= bus.addr_i;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RD_I;
                    end
                end
                S_RD_I: begin
                    if (rd_last) begin
                        cnt_q   <= '0;
                        val_i_q <= bus.mem_rdata;
                        if (same_addr) begin
                            // Nothing to exchange: both old values are the same word.
                            val_j_q <= bus.mem_rdata;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            mem_addr_q <= aj_q;
                            state_q    <= S_RD_J;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RD_J: begin
                    if (rd_last) begin
                        cnt_q       <= '0;
                        val_j_q     <= bus.mem_rdata;
                        mem_addr_q  <= ai_q;
                        mem_wdata_q <= bus.mem_rdata;
                        mem_wren_q  <= 1'b1;
                        state_q     <= S_WR_I;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WR_I: begin
                    mem_addr_q  <= aj_q;
                    mem_wdata_q <= val_i_q;
                    state_q     <= S_WR_J;
                end
                S_WR_J: begin
                    mem_wren_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    mem_wren_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.val_i     = val_i_q;
    assign bus.val_j     = val_j_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wren  = mem_wren_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_swap_engine.sv
// Bench for swap_engine: five instances covering read latency 1/2/4, the
// same-address short cut on and off, and a 16-bit/10-bit configuration,
// each attached to its own behavioural RAM with a back-door port.
module tb_swap_engine;
    localparam int NI = 5;

    typedef struct {
        int          k;
        logic [15:0] vi;
        logic [15:0] vj;
        int          c;
    } exp_t;

    typedef struct {
        int k;
        int c;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        start   [NI];
    logic [9:0]  addr_i  [NI];
    logic [9:0]  addr_j  [NI];
    logic        busy    [NI];
    logic        done    [NI];
    logic [15:0] val_i   [NI];
    logic [15:0] val_j   [NI];
    logic [9:0]  maddr   [NI];
    logic        mwren   [NI];
    logic [15:0] mwdata  [NI];
    logic [2:0]  dbg_state [NI];
    logic        bd_we   [NI];
    logic [9:0]  bd_addr [NI];
    logic [15:0] bd_data [NI];
    logic [9:0]  bd_raddr [NI];
    logic [15:0] bd_rdata [NI];

    logic [15:0] model [NI][1024];
    exp_t        exp_q[$];
    wr_t         wr_q[$];
    exp_t        mon_e;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int DW   = (k == 4) ? 16 : 8;
        localparam int AW   = (k == 4) ? 10 : 8;
        localparam int LAT  = (k == 1) ? 2 : (k == 2) ? 4 : 1;
        localparam int SKIP = (k == 3) ? 0 : 1;

        logic [DW-1:0] ram  [0:(1<<AW)-1];
        logic [DW-1:0] pipe [0:LAT-1];

        swap_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

        swap_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .SKIP_SAME(SKIP)) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .bus         (bus),
            .dbg_state_o (dbg_state[k])
        );

        assign bus.start     = start[k];
        assign bus.addr_i    = addr_i[k][AW-1:0];
        assign bus.addr_j    = addr_j[k][AW-1:0];
        assign bus.mem_rdata = pipe[LAT-1];
        assign busy[k]       = bus.busy;
        assign done[k]       = bus.done;
        assign val_i[k]      = 16'(bus.val_i);
        assign val_j[k]      = 16'(bus.val_j);
        assign maddr[k]      = 10'(bus.mem_addr);
        assign mwren[k]      = bus.mem_wren;
        assign mwdata[k]     = 16'(bus.mem_wdata);
        assign bd_rdata[k]   = 16'(ram[bd_raddr[k][AW-1:0]]);

        // RAM: write at the edge ending a wren cycle, read data LAT cycles after sampling.
        always @(posedge clk) begin
            if (bd_we[k])
                ram[bd_addr[k][AW-1:0]] <= bd_data[k][DW-1:0];
            else if (bus.mem_wren)
                ram[bus.mem_addr] <= bus.mem_wdata;
            pipe[0] <= ram[bus.mem_addr];
            for (int p = 1; p < LAT; p++)
                pipe[p] <= pipe[p-1];
        end
    end

    // Monitor: log write cycles and check every done against the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (mwren[k] && reset_n)
                wr_q.push_back('{k, cyc});
            if (done[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: inst %0d done at cycle %0d, none expected", k, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.k != k || val_i[k] !== mon_e.vi || val_j[k] !== mon_e.vj || cyc != mon_e.c) begin
                        errors++;
                        $display("FAIL done_resp: got inst %0d vi %0h vj %0h cycle %0d, expected inst %0d vi %0h vj %0h cycle %0d",
                                 k, val_i[k], val_j[k], cyc, mon_e.k, mon_e.vi, mon_e.vj, mon_e.c);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_mem(input int k, input int a, input logic [15:0] exp);
        bd_raddr[k] = 10'(a);
        #1;
        chk($sformatf("mem%0d[%0h]", k, a), bd_rdata[k], exp);
    endtask

    task automatic chk_all(input int k, input int n);
        for (int a = 0; a < n; a++)
            chk_mem(k, a, model[k][a]);
    endtask

    task automatic poke(input int k, input int a, input logic [15:0] d);
        @(negedge clk);
        bd_we[k] = 1'b1; bd_addr[k] = 10'(a); bd_data[k] = d;
        model[k][a] = d;
        @(negedge clk);
        bd_we[k] = 1'b0;
    endtask

    task automatic expect_wr(input int k, input int c);
        wr_t w;
        checks++;
        if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_cycle: inst %0d got no write, expected write in cycle %0d", k, c);
        end else begin
            w = wr_q.pop_front();
            if (w.k != k || w.c != c) begin
                errors++;
                $display("FAIL wr_cycle: got inst %0d cycle %0d expected inst %0d cycle %0d", w.k, w.c, k, c);
            end
        end
    endtask

    task automatic wait_drain(input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Driver: one swap request with its hand-computed old values and done cycle.
    task automatic do_swap(input int k, input int a, input int b,
                           input logic [15:0] evi, input logic [15:0] evj,
                           input int n, output int x);
        logic [15:0] t;
        @(negedge clk);
        start[k] = 1'b1; addr_i[k] = 10'(a); addr_j[k] = 10'(b);
        x = cyc;
        exp_q.push_back('{k, evi, evj, x + n});
        @(negedge clk);
        start[k] = 1'b0;
        addr_i[k] = 10'h155; addr_j[k] = 10'h0aa;
        chk($sformatf("busy_cycle1_inst%0d", k), busy[k], 1'b1);
        wait_drain(60);
        chk($sformatf("busy_after_done_inst%0d", k), busy[k], 1'b0);
        t = model[k][a]; model[k][a] = model[k][b]; model[k][b] = t;
    endtask

    initial begin
        int x;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0; addr_i[k] = '0; addr_j[k] = '0;
            bd_we[k] = 1'b0; bd_addr[k] = '0; bd_data[k] = '0; bd_raddr[k] = '0;
        end

        // Reset state of every instance.
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_ctl%0d", k), {busy[k], done[k], mwren[k], dbg_state[k], maddr[k]}, 64'd0);
            chk($sformatf("rst_data%0d", k), {mwdata[k], val_i[k], val_j[k]}, 64'd0);
        end
        reset_n = 1'b1;

        // Back-door preload of all RAMs with a known pattern.
        for (int a = 0; a < 1024; a++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                bd_we[k] = (k == 4) || (a < 256);
                bd_addr[k] = 10'(a);
                bd_data[k] = (k == 4) ? 16'((a * 16'd517) ^ 16'h3c5a) : 16'((a * 37 + 11) & 8'hff);
                if (bd_we[k]) model[k][a] = bd_data[k];
            end
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) bd_we[k] = 1'b0;

        // Basic swap, RD_LAT=1.
        poke(0, 3, 16'h50); poke(0, 9, 16'h02);
        wr_q.delete();
        do_swap(0, 3, 9, 16'h50, 16'h02, 7, x);
        expect_wr(0, x + 5); expect_wr(0, x + 6);
        chk("wr_extra_basic", wr_q.size(), 0);
        chk_mem(0, 3, 16'h02); chk_mem(0, 9, 16'h50);
        chk_all(0, 256);

        // Latency sweep: RD_LAT=2 and 4.
        poke(1, 3, 16'h50); poke(1, 9, 16'h02);
        do_swap(1, 3, 9, 16'h50, 16'h02, 9, x);
        expect_wr(1, x + 7); expect_wr(1, x + 8);
        chk_mem(1, 3, 16'h02); chk_mem(1, 9, 16'h50);
        chk_all(1, 256);
        poke(2, 3, 16'h50); poke(2, 9, 16'h02);
        do_swap(2, 3, 9, 16'h50, 16'h02, 13, x);
        expect_wr(2, x + 11); expect_wr(2, x + 12);
        chk_mem(2, 3, 16'h02); chk_mem(2, 9, 16'h50);
        chk_all(2, 256);
        chk("wr_extra_sweep", wr_q.size(), 0);

        // Same address with and without the short cut.
        poke(0, 7, 16'hAA);
        do_swap(0, 7, 7, 16'hAA, 16'hAA, 3, x);
        chk("wr_none_skip", wr_q.size(), 0);
        chk_mem(0, 7, 16'hAA);
        poke(3, 7, 16'hAA);
        do_swap(3, 7, 7, 16'hAA, 16'hAA, 7, x);
        expect_wr(3, x + 5); expect_wr(3, x + 6);
        chk_mem(3, 7, 16'hAA);
        chk_all(3, 256);

        // Start held high for three swaps; addresses wiggle while busy.
        @(negedge clk);
        start[0] = 1'b1; addr_i[0] = 10'd3; addr_j[0] = 10'd9;
        x = cyc;
        exp_q.push_back('{0, 16'h02, 16'h50, x + 7});
        exp_q.push_back('{0, 16'h50, 16'h02, x + 15});
        exp_q.push_back('{0, 16'h02, 16'h50, x + 23});
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 23) start[0] = 1'b0;
            if ((n % 8) >= 2 && (n % 8) <= 6) begin
                addr_i[0] = 10'd20; addr_j[0] = 10'd21;
            end else begin
                addr_i[0] = 10'd3; addr_j[0] = 10'd9;
            end
        end
        wait_drain(5);
        for (int s = 0; s < 3; s++) begin
            expect_wr(0, x + 8 * s + 5); expect_wr(0, x + 8 * s + 6);
        end
        chk("wr_extra_hs", wr_q.size(), 0);
        model[0][3] = 16'h50; model[0][9] = 16'h02;
        chk_all(0, 256);

        // Reset during WR_I: write enable drops at once, j never written.
        @(negedge clk);
        start[0] = 1'b1; addr_i[0] = 10'd3; addr_j[0] = 10'd9;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("wren_in_wr_i", mwren[0], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_wren", mwren[0], 1'b0);
        chk("rst_mid_ctl", {busy[0], done[0], dbg_state[0], maddr[0]}, 64'd0);
        chk("rst_mid_data", {mwdata[0], val_i[0], val_j[0]}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        wr_q.delete();
        chk_mem(0, 3, 16'h50); chk_mem(0, 9, 16'h02);
        do_swap(0, 3, 9, 16'h50, 16'h02, 7, x);
        expect_wr(0, x + 5); expect_wr(0, x + 6);
        chk_mem(0, 3, 16'h02); chk_mem(0, 9, 16'h50);

        // 16-bit data, 10-bit address extremes.
        poke(4, 10'h3FF, 16'hBEEF); poke(4, 0, 16'h1234);
        do_swap(4, 10'h3FF, 0, 16'hBEEF, 16'h1234, 7, x);
        expect_wr(4, x + 5); expect_wr(4, x + 6);
        chk_mem(4, 10'h3FF, 16'h1234); chk_mem(4, 0, 16'hBEEF);
        chk_all(4, 1024);
        chk("wr_extra_end", wr_q.size(), 0);
        chk("sb_empty_end", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
